// File: rtl/fmul_arbiter_if.sv
// Requester and multiplier bus of the shared floating-point multiplier arbiter.
interface fmul_arbiter_if #(
  parameter int unsigned NREQ = 4
);
  logic [NREQ-1:0]      req_valid;
  logic [32*NREQ-1:0]   req_x1;
  logic [32*NREQ-1:0]   req_x2;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      resp_valid;
  logic [31:0]          resp_y;
  logic [31:0]          mul_x1;
  logic [31:0]          mul_x2;
  logic                 mul_ready;
  logic [31:0]          mul_y;
  logic                 mul_valid;

  modport slave (
    input  req_valid, req_x1, req_x2, mul_y, mul_valid,
    output req_ready, resp_valid, resp_y, mul_x1, mul_x2, mul_ready
  );

  modport master (
    output req_valid, req_x1, req_x2, mul_y, mul_valid,
    input  req_ready, resp_valid, resp_y, mul_x1, mul_x2, mul_ready
  );
endinterface

// File: rtl/fmul_arbiter.sv
// Round-robin arbiter sharing one single-issue FP multiplier among NREQ requesters,
// with operand hold during the operation and a sticky completion watchdog.
module fmul_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  fmul_arbiter_if.slave bus,
  output logic          busy,
  output logic          err
);

  localparam int unsigned DW = 32;
  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t          state, state_d;
  logic [PW-1:0]   ptr, ptr_d, gnt, gnt_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic [DW-1:0]   x1_q, x1_d, x2_q, x2_d, y_q, y_d;
  logic [NREQ-1:0] rv_q, rv_d;
  logic            mr_q, mr_d, err_q, err_d;

  logic [DW-1:0]   x1_arr [NREQ];
  logic [DW-1:0]   x2_arr [NREQ];
  logic            found;
  logic [PW-1:0]   win, scan_idx;
  logic [PW:0]     scan_sum;

  for (genvar i = 0; i < NREQ; i++) begin : g_slice
    assign x1_arr[i] = bus.req_x1[i*DW +: DW];
    assign x2_arr[i] = bus.req_x2[i*DW +: DW];
  end

  // First requesting index after ptr, wrapping, with ptr itself checked last
  always_comb begin
    found    = 1'b0;
    win      = '0;
    scan_sum = '0;
    scan_idx = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      scan_sum = (PW+1)'(ptr) + (PW+1)'(k);
      if (scan_sum >= (PW+1)'(NREQ)) scan_sum = scan_sum - (PW+1)'(NREQ);
      scan_idx = scan_sum[PW-1:0];
      if (!found && bus.req_valid[scan_idx]) begin
        found = 1'b1;
        win   = scan_idx;
      end
    end
  end

  assign bus.req_ready  = (state == IDLE && found) ? (NREQ'(1) << win) : '0;
  assign bus.mul_x1     = x1_q;
  assign bus.mul_x2     = x2_q;
  assign bus.mul_ready  = mr_q;
  assign bus.resp_valid = rv_q;
  assign bus.resp_y     = y_q;
  assign busy           = (state != IDLE);
  assign err            = err_q;

  // Next-state and registered-output logic
  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    gnt_d   = gnt;
    cnt_d   = cnt;
    x1_d    = x1_q;
    x2_d    = x2_q;
    y_d     = y_q;
    rv_d    = '0;
    mr_d    = 1'b0;
    err_d   = err_q;
    case (state)
      IDLE: begin
        if (found) begin
          x1_d    = x1_arr[win];
          x2_d    = x2_arr[win];
          gnt_d   = win;
          ptr_d   = win;
          mr_d    = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.mul_valid) begin
          y_d     = bus.mul_y;
          rv_d    = NREQ'(1) << gnt;
          state_d = DONE;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          y_d     = '0;
          rv_d    = NREQ'(1) << gnt;
          state_d = DONE;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= PW'(NREQ - 1);
      gnt   <= '0;
      cnt   <= '0;
      x1_q  <= '0;
      x2_q  <= '0;
      y_q   <= '0;
      rv_q  <= '0;
      mr_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state <= state_d;
      ptr   <= ptr_d;
      gnt   <= gnt_d;
      cnt   <= cnt_d;
      x1_q  <= x1_d;
      x2_q  <= x2_d;
      y_q   <= y_d;
      rv_q  <= rv_d;
      mr_q  <= mr_d;
      err_q <= err_d;
    end
  end

endmodule

// File: tb/tb_fmul_arbiter.sv
// Directed self-checking bench for fmul_arbiter with a latency-programmable multiplier model.
module tb_fmul_arbiter;

  localparam int unsigned NREQ    = 4;
  localparam int unsigned TIMEOUT = 15;

  logic clk, rst, busy, err;
  int   n_tests, n_fail;
  int   mdl_lat;
  int   mcnt;
  logic stray;

  logic [31:0] rr_x2 [4] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
  logic [31:0] rr_y  [4] = '{32'h3FC00000, 32'h40400000, 32'h40900000, 32'h40C00000};
  logic [3:0]  fexp  [4] = '{4'b1000, 4'b0010, 4'b1000, 4'b1000};

  fmul_arbiter_if #(.NREQ(NREQ)) bus ();

  fmul_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy),
    .err  (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Known products for the operand pairs used below; anything else is poisoned
  function automatic logic [31:0] fmul_lut(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h40000000, 32'h40400000}: return 32'h40C00000;
      {32'h3FC00000, 32'h3F800000}: return 32'h3FC00000;
      {32'h3FC00000, 32'h40000000}: return 32'h40400000;
      {32'h3FC00000, 32'h40400000}: return 32'h40900000;
      {32'h3FC00000, 32'h40800000}: return 32'h40C00000;
      {32'hC0000000, 32'h40400000}: return 32'hC0C00000;
      {32'h00000000, 32'h3F800000}: return 32'h00000000;
      default:                      return 32'hDEADBEEF;
    endcase
  endfunction

  // Multiplier model: done pulse mdl_lat cycles after the start strobe, 0 = never
  always @(posedge clk) begin
    if (rst) begin
      mcnt          <= 0;
      bus.mul_valid <= 1'b0;
      bus.mul_y     <= '0;
    end else begin
      bus.mul_valid <= stray;
      if (bus.mul_ready) begin
        mcnt <= (mdl_lat >= 2) ? mdl_lat - 1 : 0;
      end else if (mcnt > 0) begin
        mcnt <= mcnt - 1;
        if (mcnt == 1) begin
          bus.mul_valid <= 1'b1;
          bus.mul_y     <= fmul_lut(bus.mul_x1, bus.mul_x2);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [3:0] vmask, input int idx, input logic [31:0] x1,
                       input logic [31:0] x2, input logic [31:0] y);
    logic [3:0] oh;
    oh = 4'b0001 << idx;
    bus.req_x1[idx*32 +: 32] = x1;
    bus.req_x2[idx*32 +: 32] = x2;
    bus.req_valid = vmask;
    #1;
    check("op_ready", 32'(bus.req_ready), 32'(oh));
    tick;
    bus.req_valid = '0;
    for (int c = 0; c < 30 && bus.resp_valid == '0; c++) tick;
    check("op_resp_valid", 32'(bus.resp_valid), 32'(oh));
    check("op_resp_y", bus.resp_y, y);
    tick;
    check("op_pulse_end", 32'(bus.resp_valid), 32'h0);
    check("op_idle", 32'(busy), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    mdl_lat = 2;
    stray   = 1'b0;
    rst     = 1'b1;
    bus.req_valid = '0;
    bus.req_x1    = '0;
    bus.req_x2    = '0;
    repeat (3) tick;
    rst = 1'b0;

    // Reset state
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_mul_x1", bus.mul_x1, 32'h0);
    check("rst_mul_x2", bus.mul_x2, 32'h0);
    check("rst_resp_y", bus.resp_y, 32'h0);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
    check("rst_mul_ready", 32'(bus.mul_ready), 32'h0);
    check("rst_req_ready", 32'(bus.req_ready), 32'h0);

    // Single op, cycle-exact timing
    bus.req_x1[31:0] = 32'h40000000;
    bus.req_x2[31:0] = 32'h40400000;
    bus.req_valid    = 4'b0001;
    #1;
    check("t1_ready_T", 32'(bus.req_ready), 32'h1);
    check("t1_busy_T", 32'(busy), 32'h0);
    tick;
    bus.req_valid = '0;
    check("t1_mul_ready_T1", 32'(bus.mul_ready), 32'h1);
    check("t1_busy_T1", 32'(busy), 32'h1);
    check("t1_mul_x1", bus.mul_x1, 32'h40000000);
    check("t1_mul_x2", bus.mul_x2, 32'h40400000);
    check("t1_ready_T1", 32'(bus.req_ready), 32'h0);
    tick;
    check("t1_mul_ready_T2", 32'(bus.mul_ready), 32'h0);
    tick;
    check("t1_resp_T3", 32'(bus.resp_valid), 32'h0);
    check("t1_busy_T3", 32'(busy), 32'h1);
    tick;
    check("t1_resp_T4", 32'(bus.resp_valid), 32'h1);
    check("t1_resp_y", bus.resp_y, 32'h40C00000);
    check("t1_busy_T4", 32'(busy), 32'h1);
    tick;
    check("t1_resp_T5", 32'(bus.resp_valid), 32'h0);
    check("t1_busy_T5", 32'(busy), 32'h0);

    // Round-robin with all requesters held
    rst = 1'b1;
    tick;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.req_x1[i*32 +: 32] = 32'h3FC00000;
      bus.req_x2[i*32 +: 32] = rr_x2[i];
    end
    bus.req_valid = 4'hF;
    #1;
    for (int n = 0; n < 5; n++) begin
      int g;
      g = n % 4;
      check("rr_gnt", 32'(bus.req_ready), 32'h1 << g);
      repeat (4) tick;
      check("rr_resp_valid", 32'(bus.resp_valid), 32'h1 << g);
      check("rr_resp_y", bus.resp_y, rr_y[g]);
      tick;
    end
    bus.req_valid = '0;

    // Operand hold while requester inputs churn
    mdl_lat = 5;
    bus.req_x1[95:64] = 32'hC0000000;
    bus.req_x2[95:64] = 32'h40400000;
    bus.req_valid     = 4'b0100;
    #1;
    check("hold_ready", 32'(bus.req_ready), 32'h4);
    tick;
    bus.req_valid = '0;
    for (int c = 0; c < 25 && bus.resp_valid == '0; c++) begin
      bus.req_x1[95:64] = $urandom;
      bus.req_x2[95:64] = $urandom;
      check("hold_x1", bus.mul_x1, 32'hC0000000);
      check("hold_x2", bus.mul_x2, 32'h40400000);
      tick;
    end
    check("hold_resp_valid", 32'(bus.resp_valid), 32'h4);
    check("hold_resp_y", bus.resp_y, 32'hC0C00000);
    tick;

    // Watchdog: multiplier never completes
    mdl_lat = 0;
    bus.req_x1[63:32] = 32'h3FC00000;
    bus.req_x2[63:32] = 32'h40000000;
    bus.req_valid     = 4'b0010;
    #1;
    check("wd_ready", 32'(bus.req_ready), 32'h2);
    tick;
    bus.req_valid = '0;
    repeat (TIMEOUT) tick;
    check("wd_err_early", 32'(err), 32'h0);
    check("wd_no_resp_early", 32'(bus.resp_valid), 32'h0);
    tick;
    check("wd_err", 32'(err), 32'h1);
    check("wd_resp_valid", 32'(bus.resp_valid), 32'h2);
    check("wd_resp_y", bus.resp_y, 32'h0);
    tick;
    check("wd_idle", 32'(busy), 32'h0);

    // Sticky err across successful ops; zero operand passes through
    mdl_lat = 2;
    do_op(4'b0001, 0, 32'h00000000, 32'h3F800000, 32'h00000000);
    check("err_sticky1", 32'(err), 32'h1);
    do_op(4'b1000, 3, 32'h40000000, 32'h40400000, 32'h40C00000);
    check("err_sticky2", 32'(err), 32'h1);

    // Reset mid-op, then stray done pulses
    mdl_lat = 0;
    bus.req_x1[95:64] = 32'h40000000;
    bus.req_x2[95:64] = 32'h40400000;
    bus.req_valid     = 4'b0100;
    #1;
    check("mid_ready", 32'(bus.req_ready), 32'h4);
    tick;
    bus.req_valid = '0;
    repeat (2) tick;
    check("mid_busy", 32'(busy), 32'h1);
    check("mid_mul_x1", bus.mul_x1, 32'h40000000);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_err", 32'(err), 32'h0);
    check("mid_rst_mul_x1", bus.mul_x1, 32'h0);
    check("mid_rst_mul_x2", bus.mul_x2, 32'h0);
    check("mid_rst_resp_y", bus.resp_y, 32'h0);
    check("mid_rst_resp_valid", 32'(bus.resp_valid), 32'h0);
    stray = 1'b1;
    tick;
    stray = 1'b0;
    tick;
    check("stray_busy", 32'(busy), 32'h0);
    check("stray_resp_valid", 32'(bus.resp_valid), 32'h0);
    check("stray_resp_y", bus.resp_y, 32'h0);
    mdl_lat = 2;
    do_op(4'hF, 0, 32'h3FC00000, 32'h3F800000, 32'h3FC00000);

    // Fairness: req 3 held, req 1 asserted once until served
    bus.req_x1[127:96] = 32'h3FC00000;
    bus.req_x2[127:96] = 32'h40800000;
    bus.req_x1[63:32]  = 32'h3FC00000;
    bus.req_x2[63:32]  = 32'h40000000;
    bus.req_valid      = 4'b1000;
    for (int n = 0; n < 4; n++) begin
      #1;
      for (int c = 0; c < 20 && bus.req_ready == '0; c++) tick;
      check("fair_gnt", 32'(bus.req_ready), 32'(fexp[n]));
      tick;
      if (n == 0) bus.req_valid[1] = 1'b1;
      if (n == 1) bus.req_valid[1] = 1'b0;
    end
    bus.req_valid = '0;
    for (int c = 0; c < 20 && busy; c++) tick;
    check("fair_idle", 32'(busy), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
